mpu_code_loader: RTL

MPU_CODE_LOADER -- requirements
Module: mpu_code_loader

---
 rtl/mpu_code_loader_pkg.sv | 25 ++
 rtl/mpu_code_loader_packer.sv | 59 +++++
 rtl/mpu_code_loader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mpu_code_loader_pkg.sv
// Shared MPU package: loader FSM state encoding, instruction-half address
// constant, and the helper that forms a bridge address from a word index.
package mpu_code_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_WRITE    = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_CHECK    = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERROR    = 3'd7
    } loader_state_t;

    localparam int  WORD_IDX_W = 13;
    // Bit 15 of the low half selects instruction (0) vs data (1) memory.
    localparam logic INSTR_HALF = 1'b0;

    function automatic logic [31:0] mk_bridge_addr(input logic [15:0]           top,
                                                   input logic [WORD_IDX_W-1:0] idx);
        return {top, INSTR_HALF, idx, 2'b00};
    endfunction

endpackage

// File: rtl/mpu_code_loader_packer.sv
// loader_word_packer: assembles four source bytes MSB-first into a 32-bit
// word and keeps running mod-2^32 sums of written and read-back words.
// Ports:
//   clk, rst_n        block clock, async active-low reset
//   i_clr             clear word, byte count and both sums (start of load)
//   i_byte_vld/i_byte accepted source byte
//   i_wr_acc          add current packed word to the write sum
//   i_rd_acc/i_rd_data add a read-back word to the read sum
//   o_word            packed word
//   o_last_byte       next accepted byte completes the word
//   o_sums_match      write sum equals read sum
module loader_word_packer
    import mpu_code_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte,
    input  logic        i_wr_acc,
    input  logic        i_rd_acc,
    input  logic [31:0] i_rd_data,
    output logic [31:0] o_word,
    output logic        o_last_byte,
    output logic        o_sums_match
);

    logic [31:0] r_word;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_wr_sum;
    logic [31:0] r_rd_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word     <= '0;
            r_byte_cnt <= '0;
            r_wr_sum   <= '0;
            r_rd_sum   <= '0;
        end else if (i_clr) begin
            r_word     <= '0;
            r_byte_cnt <= '0;
            r_wr_sum   <= '0;
            r_rd_sum   <= '0;
        end else begin
            if (i_byte_vld) begin
                // Shift left so the first byte of a word lands in [31:24].
                r_word     <= {r_word[23:0], i_byte};
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (i_wr_acc) r_wr_sum <= r_wr_sum + r_word;
            if (i_rd_acc) r_rd_sum <= r_rd_sum + i_rd_data;
        end
    end

    assign o_word       = r_word;
    assign o_last_byte  = (r_byte_cnt == 2'd3);
    assign o_sums_match = (r_wr_sum == r_rd_sum);

endmodule

// File: rtl/mpu_code_loader.sv
// mpu_code_loader: streams a byte image into MPU instruction memory over a
// simple bridge, reads every word back, and releases the MPU from reset only
// when the read-back sum equals the written sum.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   start, length_words                begin a load of length_words words
//   src_valid/src_ready/src_data       byte-stream source
//   bridge_addr/bridge_wr/bridge_wr_data/bridge_rd/bridge_rd_data  bridge
//   mpu_reset_n                        MPU held in reset while low
//   busy/done/error                    status
module mpu_code_loader
    import mpu_code_loader_pkg::*;
#(
    parameter logic [15:0] TOP_ADDRESS = 16'h8000,
    parameter int          RD_LATENCY  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [12:0] length_words,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic [7:0]  src_data,
    output logic [31:0] bridge_addr,
    output logic        bridge_wr,
    output logic [31:0] bridge_wr_data,
    output logic        bridge_rd,
    input  logic [31:0] bridge_rd_data,
    output logic        mpu_reset_n,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);

    loader_state_t     r_state, w_state_nxt;
    logic [12:0]       r_word_idx;
    logic [12:0]       r_len;
    logic [LAT_W-1:0]  r_lat_cnt;

    logic [12:0] w_idx_inc;
    logic        w_load;
    logic        w_byte_acc;
    logic        w_wr_acc;
    logic        w_rd_acc;
    logic        w_last_byte;
    logic        w_sums_match;
    logic [31:0] w_word;

    assign w_idx_inc = r_word_idx + 13'd1;

    loader_word_packer u_packer (
        .clk          (clk),
        .rst_n        (reset_n),
        .i_clr        (w_load),
        .i_byte_vld   (w_byte_acc),
        .i_byte       (src_data),
        .i_wr_acc     (w_wr_acc),
        .i_rd_acc     (w_rd_acc),
        .i_rd_data    (bridge_rd_data),
        .o_word       (w_word),
        .o_last_byte  (w_last_byte),
        .o_sums_match (w_sums_match)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_byte_acc  = 1'b0;
        w_wr_acc    = 1'b0;
        w_rd_acc    = 1'b0;
        src_ready   = 1'b0;
        bridge_wr   = 1'b0;
        bridge_rd   = 1'b0;
        bridge_addr = '0;
        mpu_reset_n = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        error       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                busy        = 1'b0;
                done        = (r_state == ST_DONE);
                error       = (r_state == ST_ERROR);
                mpu_reset_n = (r_state == ST_DONE);
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = (length_words == 13'd0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                src_ready  = 1'b1;
                w_byte_acc = src_valid;
                if (src_valid && w_last_byte) w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                bridge_wr   = 1'b1;
                bridge_addr = mk_bridge_addr(TOP_ADDRESS, r_word_idx);
                w_wr_acc    = 1'b1;
                w_state_nxt = (w_idx_inc == r_len) ? ST_RD_ISSUE : ST_FILL;
            end
            ST_RD_ISSUE: begin
                bridge_rd   = 1'b1;
                bridge_addr = mk_bridge_addr(TOP_ADDRESS, r_word_idx);
                w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (r_lat_cnt == LAT_LAST) begin
                    w_rd_acc    = 1'b1;
                    w_state_nxt = (w_idx_inc == r_len) ? ST_CHECK : ST_RD_ISSUE;
                end
            end
            ST_CHECK: begin
                w_state_nxt = w_sums_match ? ST_DONE : ST_ERROR;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Word index, latched length and read-latency counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word_idx <= '0;
            r_len      <= '0;
            r_lat_cnt  <= '0;
        end else begin
            if (w_load) begin
                r_word_idx <= '0;
                r_len      <= length_words;
            end else if (r_state == ST_WRITE) begin
                // Read-back restarts from word 0 once the last word is written.
                r_word_idx <= (w_idx_inc == r_len) ? 13'd0 : w_idx_inc;
            end else if (w_rd_acc) begin
                r_word_idx <= w_idx_inc;
            end

            if (r_state == ST_RD_ISSUE)   r_lat_cnt <= '0;
            else if (r_state == ST_RD_WAIT) r_lat_cnt <= r_lat_cnt + LAT_W'(1);
        end
    end

    assign bridge_wr_data = w_word;

endmodule
